t07_mmio_router: RTL and testbench

Registered, parametrised MMIO router between the CPU memory stage and four targets: Wishbone instruction memory, Wishbone data memory, external ESP32 register bank, and the SPI-TFT display. One request is latched, decoded against a parameter-defined address map, issued with a handshake, and completed with read data or an error response after a bounded timeout. It replaces the combinational decoder and gives the CPU a single busy/done contract.

---
 rtl/t07_mmio_pkg.sv | 33 +++
 rtl/t07_mmio_decode.sv | 55 +++++
 rtl/t07_mmio_router.sv | 206 ++++++++++++++++++++
 tb/tb_t07_mmio_router.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t07_mmio_pkg.sv
// Shared types and constants for the MMIO router.
//   rw_t     : CPU request kind as encoded on req_rw
//   state_t  : router FSM states
//   region_t : decoded target region
package t07_mmio_pkg;

    typedef enum logic [1:0] {
        RwIdle  = 2'b00,
        RwStore = 2'b01,
        RwLoad  = 2'b10,
        RwFetch = 2'b11
    } rw_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDone,
        StErr
    } state_t;

    typedef enum logic [2:0] {
        RegionImem,
        RegionReg,
        RegionDmem,
        RegionDisp,
        RegionNone
    } region_t;

    // Read data returned on any error response.
    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/t07_mmio_decode.sv
// Combinational address decoder for the MMIO router.
//   addr   : request address
//   rw     : request kind
//   region : region containing addr (RegionNone if unmapped)
//   legal  : request kind is permitted in that region
module t07_mmio_decode
    import t07_mmio_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] IMEM_BASE = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] IMEM_END  = ADDR_W'(1025),
    parameter logic [ADDR_W-1:0] REG_BASE  = ADDR_W'(1025),
    parameter logic [ADDR_W-1:0] REG_END   = ADDR_W'(1057),
    parameter logic [ADDR_W-1:0] DMEM_BASE = ADDR_W'(1057),
    parameter logic [ADDR_W-1:0] DMEM_END  = ADDR_W'(1793),
    parameter logic [ADDR_W-1:0] DISP_BASE = ADDR_W'(1793),
    parameter logic [ADDR_W-1:0] DISP_END  = ADDR_W'(2048)
) (
    input  logic [ADDR_W-1:0] addr,
    input  rw_t               rw,
    output region_t           region,
    output logic              legal
);

    // [base,end) test via a single unsigned subtract; addresses below base wrap high.
    function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] last);
        return (a - base) < (last - base);
    endfunction

    always_comb begin
        region = RegionNone;
        if (in_range(addr, IMEM_BASE, IMEM_END)) begin
            region = RegionImem;
        end else if (in_range(addr, REG_BASE, REG_END)) begin
            region = RegionReg;
        end else if (in_range(addr, DMEM_BASE, DMEM_END)) begin
            region = RegionDmem;
        end else if (in_range(addr, DISP_BASE, DISP_END)) begin
            region = RegionDisp;
        end
    end

    always_comb begin
        legal = 1'b0;
        case (rw)
            RwFetch: legal = (region == RegionImem);
            RwLoad:  legal = (region == RegionReg) || (region == RegionDmem);
            RwStore: legal = (region == RegionDmem) || (region == RegionDisp);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/t07_mmio_router.sv
// Registered MMIO router between the CPU memory stage and IMEM/DMEM (Wishbone),
// the external register bank and the display.
//   CPU  : req_valid, req_rw, req_addr, req_wdata -> cpu_busy, rdata, instr, done, err
//   WB   : wb_read, wb_write, wb_addr, wb_wdata <- wb_rdata, wb_done
//   REG  : reg_read, reg_addr <- reg_rdata, reg_ack, reg_cs
//   DISP : disp_write, disp_addr, disp_data <- disp_busy
module t07_mmio_router
    import t07_mmio_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] IMEM_BASE = ADDR_W'(0),
    parameter logic [ADDR_W-1:0] IMEM_END  = ADDR_W'(1025),
    parameter logic [ADDR_W-1:0] REG_BASE  = ADDR_W'(1025),
    parameter logic [ADDR_W-1:0] REG_END   = ADDR_W'(1057),
    parameter logic [ADDR_W-1:0] DMEM_BASE = ADDR_W'(1057),
    parameter logic [ADDR_W-1:0] DMEM_END  = ADDR_W'(1793),
    parameter logic [ADDR_W-1:0] DISP_BASE = ADDR_W'(1793),
    parameter logic [ADDR_W-1:0] DISP_END  = ADDR_W'(2048),
    parameter logic [7:0]        WB_PREFIX = 8'h33,
    parameter int unsigned       TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              cpu_busy,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] instr,
    output logic              done,
    output logic              err,
    output logic              wb_read,
    output logic              wb_write,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_rdata,
    input  logic              wb_done,
    output logic              reg_read,
    output logic [4:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ack,
    input  logic              reg_cs,
    output logic              disp_write,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              disp_busy
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [DATA_W-1:0] BAD_WORD   = DATA_W'(BAD_DATA);

    state_t            state_q, state_d;
    rw_t               rw_q;
    region_t           region_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_d, instr_d;
    region_t           dec_region;
    logic              dec_legal;
    logic              accept;
    logic              load_req;

    t07_mmio_decode #(
        .ADDR_W   (ADDR_W),
        .IMEM_BASE(IMEM_BASE),
        .IMEM_END (IMEM_END),
        .REG_BASE (REG_BASE),
        .REG_END  (REG_END),
        .DMEM_BASE(DMEM_BASE),
        .DMEM_END (DMEM_END),
        .DISP_BASE(DISP_BASE),
        .DISP_END (DISP_END)
    ) u_decode (
        .addr  (req_addr),
        .rw    (rw_t'(req_rw)),
        .region(dec_region),
        .legal (dec_legal)
    );

    assign accept   = (state_q == StIdle) && req_valid && (req_rw != 2'b00);
    assign cpu_busy = accept || (state_q == StIssue) || (state_q == StWait);
    assign done     = (state_q == StDone);
    assign err      = (state_q == StErr);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata;
        instr_d    = instr;
        load_req   = 1'b0;
        wb_read    = 1'b0;
        wb_write   = 1'b0;
        reg_read   = 1'b0;
        disp_write = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (dec_legal) begin
                        load_req = 1'b1;
                        cnt_d    = '0;
                        state_d  = StIssue;
                    end else begin
                        rdata_d = BAD_WORD;
                        instr_d = BAD_WORD;
                        state_d = StErr;
                    end
                end
            end
            StIssue: begin
                case (region_q)
                    RegionImem, RegionDmem: begin
                        wb_read  = (rw_q != RwStore);
                        wb_write = (rw_q == RwStore);
                        state_d  = StWait;
                    end
                    RegionReg: begin
                        if (reg_cs) begin
                            reg_read = 1'b1;
                            state_d  = StWait;
                        end
                    end
                    RegionDisp: begin
                        // Display writes are posted: no response phase.
                        if (!disp_busy) begin
                            disp_write = 1'b1;
                            state_d    = StDone;
                        end
                    end
                    default: begin
                        rdata_d = BAD_WORD;
                        instr_d = BAD_WORD;
                        state_d = StErr;
                    end
                endcase
                // Stalled on reg_cs / disp_busy: this cycle counts toward the timeout.
                if (state_d == StIssue) begin
                    if (cnt_q == TIMEOUT_CNT) begin
                        rdata_d = BAD_WORD;
                        instr_d = BAD_WORD;
                        state_d = StErr;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StWait: begin
                reg_read = (region_q == RegionReg);
                // Completion is checked first so it wins over a same-cycle timeout.
                if (region_q == RegionReg && reg_ack) begin
                    rdata_d = reg_rdata;
                    state_d = StDone;
                end else if (region_q != RegionReg && wb_done) begin
                    if (rw_q == RwFetch) begin
                        instr_d = wb_rdata;
                    end else if (rw_q == RwLoad) begin
                        rdata_d = wb_rdata;
                    end
                    state_d = StDone;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    rdata_d = BAD_WORD;
                    instr_d = BAD_WORD;
                    state_d = StErr;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rw_q      <= RwIdle;
            region_q  <= RegionNone;
            cnt_q     <= '0;
            rdata     <= '0;
            instr     <= '0;
            wb_addr   <= '0;
            wb_wdata  <= '0;
            reg_addr  <= '0;
            disp_addr <= '0;
            disp_data <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata   <= rdata_d;
            instr   <= instr_d;
            if (load_req) begin
                rw_q      <= rw_t'(req_rw);
                region_q  <= dec_region;
                wb_addr   <= {WB_PREFIX, req_addr[ADDR_W-9:0]};
                wb_wdata  <= req_wdata;
                reg_addr  <= req_addr[4:0];
                disp_addr <= req_addr;
                disp_data <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_t07_mmio_router.sv
// Directed self-checking bench for t07_mmio_router.
// Each cycle: inputs are driven 1 time unit after the rising edge and outputs
// are sampled 1 time unit later, well away from the next edge.
module tb_t07_mmio_router;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_rw = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        cpu_busy;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic        done;
    logic        err;
    logic        wb_read;
    logic        wb_write;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata = '0;
    logic        wb_done = 1'b0;
    logic        reg_read;
    logic [4:0]  reg_addr;
    logic [31:0] reg_rdata = '0;
    logic        reg_ack = 1'b0;
    logic        reg_cs = 1'b0;
    logic        disp_write;
    logic [31:0] disp_addr;
    logic [31:0] disp_data;
    logic        disp_busy = 1'b0;

    logic [3:0]  strobes;
    assign strobes = {wb_read, wb_write, reg_read, disp_write};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    t07_mmio_router dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .cpu_busy  (cpu_busy),
        .rdata     (rdata),
        .instr     (instr),
        .done      (done),
        .err       (err),
        .wb_read   (wb_read),
        .wb_write  (wb_write),
        .wb_addr   (wb_addr),
        .wb_wdata  (wb_wdata),
        .wb_rdata  (wb_rdata),
        .wb_done   (wb_done),
        .reg_read  (reg_read),
        .reg_addr  (reg_addr),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .reg_cs    (reg_cs),
        .disp_write(disp_write),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_busy (disp_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic request(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic drop_request;
        req_valid = 1'b0;
        req_rw    = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({cpu_busy, done, err, strobes} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0", {cpu_busy, done, err, strobes});
        end
        n_cmp++;
        if ({wb_addr, wb_wdata, disp_addr, disp_data, reg_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_addr: wb_addr=%h wb_wdata=%h disp_addr=%h disp_data=%h reg_addr=%h want 0",
                     wb_addr, wb_wdata, disp_addr, disp_data, reg_addr);
        end
        n_cmp++;
        if ({rdata, instr} !== 64'b0) begin
            n_bad++;
            $display("FAIL reset_data: rdata=%h instr=%h want 0", rdata, instr);
        end
        rst = 1'b0;
        tick();
    endtask

    // Fetch 0x10 with wb_done two cycles after the strobe: done in cycle 4.
    task automatic test_fetch;
        request(2'b11, 32'h10, 32'h0);
        settle();
        n_cmp++;
        if (cpu_busy !== 1'b1 || strobes !== 4'b0) begin
            n_bad++;
            $display("FAIL fetch_accept: busy=%b strobes=%b want 1/0000", cpu_busy, strobes);
        end
        tick(); // cycle 1, ISSUE
        n_cmp++;
        if (wb_read !== 1'b1 || wb_write !== 1'b0 || wb_addr !== 32'h33000010) begin
            n_bad++;
            $display("FAIL fetch_issue: rd=%b wr=%b addr=%h want 1/0/33000010", wb_read, wb_write, wb_addr);
        end
        tick(); // cycle 2, WAIT
        n_cmp++;
        if (wb_read !== 1'b0 || cpu_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fetch_wait: rd=%b busy=%b want 0/1", wb_read, cpu_busy);
        end
        tick(); // cycle 3, wb_done
        wb_done  = 1'b1;
        wb_rdata = 32'h00500093;
        settle();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_early_done: got %b want 0", done);
        end
        tick(); // cycle 4, DONE
        wb_done  = 1'b0;
        wb_rdata = 32'h0;
        n_cmp++;
        if (done !== 1'b1 || instr !== 32'h00500093 || cpu_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_done: done=%b instr=%h busy=%b want 1/00500093/0", done, instr, cpu_busy);
        end
        drop_request();
        tick();
        n_cmp++;
        if (done !== 1'b0 || instr !== 32'h00500093) begin
            n_bad++;
            $display("FAIL fetch_after: done=%b instr=%h want 0/00500093", done, instr);
        end
    endtask

    // Load 0x402 (register bank) with reg_cs low for 3 cycles.
    task automatic test_reg_load;
        request(2'b10, 32'h402, 32'h0);
        reg_cs = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (reg_read !== 1'b0 || cpu_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL reg_cs_wait[%0d]: reg_read=%b busy=%b want 0/1", i, reg_read, cpu_busy);
            end
            tick();
        end
        reg_cs = 1'b1;
        settle();
        n_cmp++;
        if (reg_read !== 1'b1 || reg_addr !== 5'd2) begin
            n_bad++;
            $display("FAIL reg_issue: reg_read=%b reg_addr=%0d want 1/2", reg_read, reg_addr);
        end
        tick(); // WAIT
        reg_ack   = 1'b1;
        reg_rdata = 32'h12345678;
        settle();
        n_cmp++;
        if (reg_read !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reg_hold: reg_read=%b done=%b want 1/0", reg_read, done);
        end
        tick(); // DONE
        reg_ack = 1'b0;
        reg_cs  = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || rdata !== 32'h12345678 || reg_read !== 1'b0) begin
            n_bad++;
            $display("FAIL reg_done: done=%b rdata=%h reg_read=%b want 1/12345678/0", done, rdata, reg_read);
        end
        drop_request();
        tick();
    endtask

    // Store 0x500 to DMEM; wb_done three cycles after the strobe.
    task automatic test_dmem_store;
        int writes;
        writes = 0;
        request(2'b01, 32'h500, 32'hCAFEF00D);
        tick(); // ISSUE
        if (wb_write === 1'b1) writes++;
        n_cmp++;
        if (wb_write !== 1'b1 || wb_read !== 1'b0 || wb_wdata !== 32'hCAFEF00D || wb_addr !== 32'h33000500) begin
            n_bad++;
            $display("FAIL store_issue: wr=%b rd=%b wdata=%h addr=%h want 1/0/CAFEF00D/33000500",
                     wb_write, wb_read, wb_wdata, wb_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb_write === 1'b1) writes++;
        end
        wb_done = 1'b1;
        settle();
        n_cmp++;
        if (cpu_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL store_busy: got %b want 1", cpu_busy);
        end
        tick(); // DONE
        wb_done = 1'b0;
        n_cmp++;
        if (writes !== 1) begin
            n_bad++;
            $display("FAIL store_pulses: got %0d want 1", writes);
        end
        n_cmp++;
        if (done !== 1'b1 || cpu_busy !== 1'b0 || rdata !== 32'h12345678) begin
            n_bad++;
            $display("FAIL store_done: done=%b busy=%b rdata=%h want 1/0/12345678", done, cpu_busy, rdata);
        end
        drop_request();
        tick();
    endtask

    // Store to the first display address while the display is busy for 5 cycles.
    task automatic test_disp_store;
        int pulses;
        pulses = 0;
        disp_busy = 1'b1;
        request(2'b01, 32'h701, 32'hA5A55A5A);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (disp_write === 1'b1 || wb_write === 1'b1) pulses++;
            tick();
        end
        disp_busy = 1'b0;
        settle();
        if (disp_write === 1'b1) pulses++;
        n_cmp++;
        if (disp_write !== 1'b1 || disp_addr !== 32'h701 || disp_data !== 32'hA5A55A5A) begin
            n_bad++;
            $display("FAIL disp_issue: wr=%b addr=%h data=%h want 1/00000701/A5A55A5A",
                     disp_write, disp_addr, disp_data);
        end
        tick(); // DONE
        n_cmp++;
        if (pulses !== 1 || done !== 1'b1 || disp_write !== 1'b0) begin
            n_bad++;
            $display("FAIL disp_done: pulses=%0d done=%b wr=%b want 1/1/0", pulses, done, disp_write);
        end
        drop_request();
        tick();
    endtask

    // 0x700 is the last DMEM word, not display; minimum Wishbone latency.
    task automatic test_min_latency;
        request(2'b01, 32'h700, 32'h0BADF00D);
        tick(); // cycle 1
        n_cmp++;
        if (wb_write !== 1'b1 || disp_write !== 1'b0 || wb_addr !== 32'h33000700) begin
            n_bad++;
            $display("FAIL edge_issue: wb_wr=%b disp_wr=%b addr=%h want 1/0/33000700",
                     wb_write, disp_write, wb_addr);
        end
        tick(); // cycle 2
        wb_done = 1'b1;
        settle();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL minlat_early: done=%b want 0", done);
        end
        tick(); // cycle 3
        wb_done = 1'b0;
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL minlat_done: done=%b want 1", done);
        end
        drop_request();
        tick();
    endtask

    // Illegal combinations: store to REG, load unmapped, fetch from REG base.
    task automatic test_illegal;
        logic [1:0]  rws   [3];
        logic [31:0] addrs [3];
        rws[0] = 2'b01; addrs[0] = 32'h402;
        rws[1] = 2'b10; addrs[1] = 32'h800;
        rws[2] = 2'b11; addrs[2] = 32'h401;
        for (int i = 0; i < 3; i++) begin
            request(rws[i], addrs[i], 32'h1);
            settle();
            n_cmp++;
            if (cpu_busy !== 1'b1 || strobes !== 4'b0) begin
                n_bad++;
                $display("FAIL illegal_accept[%0d]: busy=%b strobes=%b want 1/0000", i, cpu_busy, strobes);
            end
            tick();
            n_cmp++;
            if (err !== 1'b1 || done !== 1'b0 || strobes !== 4'b0 || cpu_busy !== 1'b0
                || rdata !== 32'hDEADBEEF || instr !== 32'hDEADBEEF) begin
                n_bad++;
                $display("FAIL illegal_err[%0d]: err=%b done=%b strobes=%b busy=%b rdata=%h instr=%h",
                         i, err, done, strobes, cpu_busy, rdata, instr);
            end
            drop_request();
            tick();
            n_cmp++;
            if (err !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal_pulse[%0d]: err=%b want 0", i, err);
            end
        end
    endtask

    // Load 0x500 with no wb_done: error after the timeout window.
    task automatic test_timeout;
        int err_at;
        logic seen_done;
        err_at    = -1;
        seen_done = 1'b0;
        request(2'b10, 32'h500, 32'h0);
        tick();
        n_cmp++;
        if (wb_read !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_issue: rd=%b want 1", wb_read);
        end
        for (int i = 1; i <= TIMEOUT + 10 && err_at < 0; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
            if (err === 1'b1) begin
                err_at = i;
                n_cmp++;
                if (rdata !== 32'hDEADBEEF || instr !== 32'hDEADBEEF) begin
                    n_bad++;
                    $display("FAIL timeout_data: rdata=%h instr=%h want DEADBEEF", rdata, instr);
                end
            end
        end
        drop_request();
        n_cmp++;
        if (err_at < TIMEOUT || err_at > TIMEOUT + 2 || seen_done) begin
            n_bad++;
            $display("FAIL timeout_cycle: err after %0d cycles done_seen=%b want %0d..%0d/0",
                     err_at, seen_done, TIMEOUT, TIMEOUT + 2);
        end
        tick();
        n_cmp++;
        if (err !== 1'b0 || cpu_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_after: err=%b busy=%b want 0/0", err, cpu_busy);
        end
    endtask

    // Reset in WAIT aborts immediately; following fetch runs normally.
    task automatic test_reset_mid;
        request(2'b10, 32'h500, 32'h0);
        tick(); // ISSUE
        tick(); // WAIT
        n_cmp++;
        if (cpu_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_busy: got %b want 1", cpu_busy);
        end
        drop_request();
        rst = 1'b1;
        settle();
        n_cmp++;
        if ({cpu_busy, done, err, strobes} !== 7'b0 || wb_addr !== 32'h0 || rdata !== 32'h0 || instr !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_reset: ctrl=%b wb_addr=%h rdata=%h instr=%h want 0",
                     {cpu_busy, done, err, strobes}, wb_addr, rdata, instr);
        end
        tick();
        rst = 1'b0;
        tick();
        request(2'b11, 32'h20, 32'h0);
        tick();
        n_cmp++;
        if (wb_read !== 1'b1 || wb_addr !== 32'h33000020) begin
            n_bad++;
            $display("FAIL post_reset_issue: rd=%b addr=%h want 1/33000020", wb_read, wb_addr);
        end
        tick();
        wb_done  = 1'b1;
        wb_rdata = 32'h00A00113;
        tick();
        wb_done = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || instr !== 32'h00A00113) begin
            n_bad++;
            $display("FAIL post_reset_done: done=%b instr=%h want 1/00A00113", done, instr);
        end
        drop_request();
        tick();
    endtask

    // Request held through DONE is re-accepted in the following IDLE cycle.
    task automatic test_back_to_back;
        request(2'b11, 32'h400, 32'h0);
        tick();
        n_cmp++;
        if (wb_read !== 1'b1 || wb_addr !== 32'h33000400) begin
            n_bad++;
            $display("FAIL b2b_issue1: rd=%b addr=%h want 1/33000400", wb_read, wb_addr);
        end
        tick();
        wb_done  = 1'b1;
        wb_rdata = 32'h11111111;
        tick(); // DONE, request still held
        wb_done = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || instr !== 32'h11111111 || cpu_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done1: done=%b instr=%h busy=%b want 1/11111111/0", done, instr, cpu_busy);
        end
        tick(); // IDLE, re-accept
        n_cmp++;
        if (cpu_busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_reaccept: busy=%b done=%b want 1/0", cpu_busy, done);
        end
        tick();
        n_cmp++;
        if (wb_read !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_issue2: rd=%b want 1", wb_read);
        end
        drop_request();
        tick();
        wb_done  = 1'b1;
        wb_rdata = 32'h22222222;
        tick();
        wb_done = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || instr !== 32'h22222222) begin
            n_bad++;
            $display("FAIL b2b_done2: done=%b instr=%h want 1/22222222", done, instr);
        end
        tick();
        n_cmp++;
        if (cpu_busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0/0", cpu_busy, done);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fetch();
        test_reg_load();
        test_dmem_store();
        test_disp_store();
        test_min_latency();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
